// File: rtl/nist5_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nist5_pkg
//  Purpose  : Shared types and constants for the NIST5 nonce collection path:
//             result record, collector state encoding, default blanking depth.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package nist5_pkg;

  // One hash-core hit as stored in the result FIFO.
  typedef struct packed {
    logic [31:0] nonce;
    logic [31:0] hash;
  } result_t;

  // Collector control state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // Hash-core pipeline depth: results appearing this many cycles after new
  // work (counting the work_new cycle itself) still belong to the old block.
  localparam int BLANK_DEFAULT = 274;

endpackage : nist5_pkg
`default_nettype wire

// File: rtl/result_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : result_fifo
//  Purpose  : Synchronous first-word-fall-through FIFO of result_t records
//             with a synchronous flush.
//  Ports    : clk, reset_n      clock, asynchronous active-low reset
//             flush             empty the FIFO next cycle (wins over push/pop)
//             push, push_data   write request and record
//             pop               remove head (ignored when empty)
//             head_data         head record, zero while empty
//             head_valid        FIFO holds at least one record
//             count             records held
//             written           push actually stored this cycle
//             overflow          push rejected because FIFO full and no pop
//  Revision : 1.0  initial release
// ============================================================================
module result_fifo
  import nist5_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   push,
  input  result_t                push_data,
  input  logic                   pop,
  output result_t                head_data,
  output logic                   head_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   written,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);

  result_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;

  logic full;
  logic do_pop;
  logic do_push;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && (count_q != '0) && !flush;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && !flush && (!full || do_pop);

  assign written  = do_push;
  assign overflow = push && !flush && full && !do_pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Pointers are AW bits wide, so DEPTH (a power of two) wraps for free.
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: nothing is visible until count_q says so.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  assign head_valid = (count_q != '0);
  assign head_data  = head_valid ? mem[rd_ptr_q] : '0;
  assign count      = count_q;

endmodule : result_fifo
`default_nettype wire

// File: rtl/nonce_collector.sv
`default_nettype none
// ============================================================================
//  Module   : nonce_collector
//  Purpose  : Collects nonce/hash hits from a hash core into a result FIFO,
//             discarding stale hits while the core pipeline drains after new
//             work and suppressing back-to-back duplicate nonces.
//  Ports    : clk, reset_n            clock, asynchronous active-low reset
//             work_new                pulse: new block loaded into core
//             nonce_found, nonce_out,
//             hash_out                core hit flag and its nonce/hash
//             res_valid, res_ready,
//             res_nonce, res_hash     FWFT result stream
//             fifo_count              results held
//             drop_count              results lost to full FIFO (saturating)
//             blanking                high while stale results are discarded
//  Revision : 1.0  initial release
// ============================================================================
module nonce_collector
  import nist5_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int BLANK = BLANK_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   work_new,
  input  logic                   nonce_found,
  input  logic [31:0]            nonce_out,
  input  logic [31:0]            hash_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [31:0]            res_nonce,
  output logic [31:0]            res_hash,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [15:0]            drop_count,
  output logic                   blanking
);

  localparam int CW = (BLANK > 1) ? $clog2(BLANK) : 1;

  state_t        state_q, state_d;
  logic [CW-1:0] blank_cnt_q, blank_cnt_d;

  logic [31:0] last_nonce_q;
  logic        last_valid_q;
  logic [15:0] drop_q;

  logic    push_req;
  logic    pop_req;
  logic    written;
  logic    overflow;
  result_t push_data;
  result_t head_data;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      blank_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      blank_cnt_q <= blank_cnt_d;
    end
  end

  // The counter is loaded with BLANK-1 and decremented every BLANK cycle; the
  // FSM leaves BLANK on the edge where the decremented value reaches 0, so the
  // work_new cycle plus the BLANK-state cycles add up to BLANK discarded cycles.
  always_comb begin
    state_d     = state_q;
    blank_cnt_d = blank_cnt_q;
    if (work_new) begin
      state_d     = ST_BLANK;
      blank_cnt_d = CW'(BLANK - 1);
    end else begin
      case (state_q)
        ST_BLANK: begin
          if (blank_cnt_q <= CW'(1)) begin
            state_d     = ST_RUN;
            blank_cnt_d = '0;
          end else begin
            blank_cnt_d = blank_cnt_q - CW'(1);
          end
        end
        default: begin
          state_d     = state_q;
          blank_cnt_d = blank_cnt_q;
        end
      endcase
    end
  end

  assign blanking = (state_q == ST_BLANK);

  // --------------------------------------------------------------------------
  // Hit filtering
  // --------------------------------------------------------------------------
  // The core may report the same winning nonce on consecutive cycles; only the
  // first report is kept. A hit in the work_new cycle belongs to the old block.
  assign push_req = (state_q == ST_RUN) && nonce_found && !work_new &&
                    !(last_valid_q && (nonce_out == last_nonce_q));
  assign pop_req  = res_valid && res_ready;

  assign push_data.nonce = nonce_out;
  assign push_data.hash  = hash_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_nonce_q <= '0;
      last_valid_q <= 1'b0;
    end else if (work_new) begin
      last_nonce_q <= '0;
      last_valid_q <= 1'b0;
    end else if (written) begin
      last_nonce_q <= nonce_out;
      last_valid_q <= 1'b1;
    end
  end

  // Lost results survive new work; only a reset clears the tally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_q <= '0;
    end else if (overflow && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_count = drop_q;

  // --------------------------------------------------------------------------
  // Result storage
  // --------------------------------------------------------------------------
  result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (work_new),
    .push       (push_req),
    .push_data  (push_data),
    .pop        (pop_req),
    .head_data  (head_data),
    .head_valid (res_valid),
    .count      (fifo_count),
    .written    (written),
    .overflow   (overflow)
  );

  assign res_nonce = head_data.nonce;
  assign res_hash  = head_data.hash;

endmodule : nonce_collector
`default_nettype wire
